// File: rtl/wb_grf.sv
// wb_grf: write-back general register file with status counters.
//
// Holds $1..$31 (32 bits each); $0 reads as zero and writes to it are dropped.
// Reads are combinational. A write on We with A3 != 0 also latches WPC into
// LastWPC. Every edge with Commit=1 bumps RetireCnt (wraps mod 2^32).
// Rst is synchronous, active-high and overrides any same-edge write or count.
// All state also starts at zero at time zero.
//
// Optional feature (macro GRF_BYPASS_EN): when defined, a read of the address
// being written this cycle returns WD instead of the stored value. The bypass
// is suppressed while Rst is high. When undefined, reads see stored data only.
//
// Ports:
//   Clk        in   1   rising-edge clock
//   Rst        in   1   synchronous active-high reset
//   We         in   1   write enable
//   A3         in   5   write address
//   WD         in  32   write data
//   WPC        in  32   PC of writing instruction
//   Commit     in   1   W stage holds a valid instruction
//   A1, A2     in   5   read addresses
//   RD1, RD2   out 32   read data
//   RetireCnt  out 32   committed-instruction count
//   LastWPC    out 32   WPC of most recent non-$0 write
module wb_grf (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        We,
  input  logic [4:0]  A3,
  input  logic [31:0] WD,
  input  logic [31:0] WPC,
  input  logic        Commit,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] RetireCnt,
  output logic [31:0] LastWPC
);

  // Declaration initialisers give the zeroed state at time zero.
  logic [31:0] regs_q [1:31] = '{default: 32'h0};
  logic [31:0] regs_d [1:31];
  logic [31:0] retire_cnt_q = 32'h0;
  logic [31:0] retire_cnt_d;
  logic [31:0] last_wpc_q = 32'h0;
  logic [31:0] last_wpc_d;

  logic        wr_fire;
  logic [31:0] rd1_stored;
  logic [31:0] rd2_stored;

  // Write request that actually targets a real register (reset handled in the flop block).
  assign wr_fire = We && (A3 != 5'd0);

  always_comb begin
    regs_d       = regs_q;
    last_wpc_d   = last_wpc_q;
    retire_cnt_d = retire_cnt_q;
    if (wr_fire) begin
      regs_d[A3] = WD;
      last_wpc_d = WPC;
    end
    if (Commit) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      regs_q       <= '{default: 32'h0};
      retire_cnt_q <= 32'h0;
      last_wpc_q   <= 32'h0;
    end else begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
      last_wpc_q   <= last_wpc_d;
    end
  end

  always_comb begin
    rd1_stored = 32'h0;
    rd2_stored = 32'h0;
    if (A1 != 5'd0) rd1_stored = regs_q[A1];
    if (A2 != 5'd0) rd2_stored = regs_q[A2];
  end

`ifdef GRF_BYPASS_EN
  logic byp_en;
  assign byp_en = !Rst && wr_fire;

  always_comb begin
    RD1 = rd1_stored;
    RD2 = rd2_stored;
    if (byp_en && (A1 == A3)) RD1 = WD;
    if (byp_en && (A2 == A3)) RD2 = WD;
  end
`else
  always_comb begin
    RD1 = rd1_stored;
    RD2 = rd2_stored;
  end
`endif

  assign RetireCnt = retire_cnt_q;
  assign LastWPC   = last_wpc_q;

endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 SHALL: clock and reset ports.
- Clk  input  1  rising-edge clock, single clock domain.
- Rst  input  1  synchronous, active-high reset.

REQ-002 SHALL: write-back port, driven by the W-stage pipeline register.
- We  input  1  register write enable.
- A3  input  5  destination register number.
- WD  input  32  write data.
- WPC  input  32  PC of the writing instruction.
- Commit  input  1  W-stage holds a valid (non-bubble) instruction.

REQ-003 SHALL: read ports, used by the D stage.
- A1  input  5  read address 1.
- A2  input  5  read address 2.
- RD1  output  32  read data 1.
- RD2  output  32  read data 2.

REQ-004 SHALL: status ports.
- RetireCnt  output  32  count of committed instructions.
- LastWPC  output  32  WPC of the most recent non-$0 register write.

Function
REQ-005 SHALL: hold 31 general registers, $1..$31, each 32 bits wide.
REQ-006 SHALL: hardwire $0 to read as 0; a write to A3=0 is discarded.
REQ-007 SHALL: on a rising edge with Rst=0, We=1 and A3!=0, set reg[A3] <= WD and LastWPC <= WPC.
REQ-008 SHALL: with We=0 or A3=0, leave the register contents and LastWPC unchanged.
REQ-009 SHALL: make RD1/RD2 combinational from A1/A2 and the stored contents, with zero-cycle latency.
REQ-010 SHALL: on a rising edge with Rst=0 and Commit=1, increment RetireCnt by 1, modulo 2^32.
- 0xFFFFFFFF wraps to 0x00000000 with no flag.
REQ-011 SHALL: treat Commit and We independently.
- Commit=1 with We=0 still counts.
- We=1 with Commit=0 still writes.
REQ-012 SHALL: serve two reads of the same address with identical data on RD1 and RD2.
REQ-013 SHALL: never stall and never backpressure; every asserted We is accepted on that edge.

Reset
REQ-014 SHALL: on a rising edge with Rst=1, clear $1..$31, RetireCnt and LastWPC to 0.
REQ-015 SHALL: let Rst win over a simultaneous We or Commit; that write and that count are lost.
REQ-016 SHALL: keep RD1/RD2 reflecting stored contents (0 after reset) while Rst=1, with the bypass disabled.
REQ-017 SHALL: initialise all state to 0 at time zero, so it equals the post-reset state before the first edge.

Configuration
REQ-018 SHALL: compile the internal write-to-read bypass only when macro GRF_BYPASS_EN is defined.
REQ-019 SHALL: with GRF_BYPASS_EN defined, drive RDx = WD when Rst=0, We=1, A3!=0 and Ax==A3; otherwise RDx = stored value.
REQ-020 SHALL: with GRF_BYPASS_EN undefined, drive RDx = stored value only.
- A same-cycle read of A3 returns the old value.
- The new value is visible from the next cycle.

Verification
REQ-021 SHALL: write/read.
- Stimulus: We=1, A3=5, WD=0x12345678, WPC=0x3000 for one edge; then A1=5.
- Response: RD1=0x12345678, LastWPC=0x3000.
REQ-022 SHALL: $0 write.
- Stimulus: We=1, A3=0, WD=0xDEADBEEF; then A1=0, A2=0.
- Response: RD1=RD2=0; LastWPC unchanged.
REQ-023 SHALL: same-cycle bypass.
- Stimulus: reg[7]=0x1; in one cycle We=1, A3=7, WD=0xAA, A1=7.
- Response before the edge: RD1=0xAA with GRF_BYPASS_EN, RD1=0x1 without it.
- Response after the edge: RD1=0xAA in both builds.
REQ-024 SHALL: reset priority.
- Stimulus: Rst=1 together with We=1, A3=3, WD=0x55 and Commit=1 on one edge.
- Response: reg[3]=0, RetireCnt=0, LastWPC=0.
REQ-025 SHALL: counter wrap.
- Stimulus: force RetireCnt to 0xFFFFFFFE; apply Commit=1 for 3 edges with We=0.
- Response: RetireCnt sequence 0xFFFFFFFF, 0x0, 0x1; no register changed.
REQ-026 SHALL: full sweep.
- Stimulus: write reg[i]=i*0x01010101 for i=1..31; read all pairs (A1=i, A2=31-i).
- Response: every value matches; RD for address 0 = 0.
